// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller and its digit counters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } sw_state_e;

    localparam int unsigned MSEC_MOD_DEF = 10;
    localparam int unsigned SEC_MOD_DEF  = 60;
    localparam int unsigned MIN_MOD_DEF  = 60;
    localparam int unsigned HOUR_MOD_DEF = 24;

    // Counter width for a mod-m digit; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// Mod-N counter stage; carry_out fires on the increment that wraps N-1 back to 0.
module stopwatch_digit
    import stopwatch_pkg::*;
#(
    parameter  int unsigned N = 10,
    localparam int unsigned W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_in,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         carry_out
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Clear has priority over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc_in) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign carry_out = inc_in && (count == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, STOP/RUN/CLEAR FSM and a chained
// tenths:seconds:minutes:hours counter that rolls over silently.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MSEC_MOD = MSEC_MOD_DEF,
    parameter int unsigned SEC_MOD  = SEC_MOD_DEF,
    parameter int unsigned MIN_MOD  = MIN_MOD_DEF,
    parameter int unsigned HOUR_MOD = HOUR_MOD_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              btn_run_stop,
    input  logic                              btn_clear,
    input  logic                              tick,
    output logic                              div_en,
    output logic                              div_clear,
    output logic [cnt_width(MSEC_MOD)-1:0]    msec,
    output logic [cnt_width(SEC_MOD)-1:0]     sec,
    output logic [cnt_width(MIN_MOD)-1:0]     min,
    output logic [cnt_width(HOUR_MOD)-1:0]    hour,
    output logic                              running
);

    sw_state_e state;
    logic      armed;
    logic      rs_prev;
    logic      clr_prev;
    logic      rs_pulse_c;
    logic      clr_pulse_c;
    logic      count_en_c;
    logic      clear_cnt_c;
    logic      msec_carry;
    logic      sec_carry;
    logic      min_carry;
    logic      hour_carry_unused;

    // armed stays low for the first edge after reset so a button held across
    // release looks like a steady level rather than a fresh press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            rs_prev  <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            armed    <= 1'b1;
            rs_prev  <= btn_run_stop;
            clr_prev <= btn_clear;
        end
    end

    assign rs_pulse_c  = armed && btn_run_stop && !rs_prev;
    assign clr_pulse_c = armed && btn_clear && !clr_prev;

    // State and its decoded outputs update together so the outputs stay registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= STOP;
            running   <= 1'b0;
            div_en    <= 1'b0;
            div_clear <= 1'b0;
        end else begin
            case (state)
                STOP: begin
                    if (clr_pulse_c) begin
                        state     <= CLEAR;
                        div_clear <= 1'b1;
                    end else if (rs_pulse_c) begin
                        state   <= RUN;
                        running <= 1'b1;
                        div_en  <= 1'b1;
                    end
                end
                RUN: begin
                    if (rs_pulse_c) begin
                        state   <= STOP;
                        running <= 1'b0;
                        div_en  <= 1'b0;
                    end
                end
                CLEAR: begin
                    state     <= STOP;
                    div_clear <= 1'b0;
                end
                default: begin
                    state     <= STOP;
                    running   <= 1'b0;
                    div_en    <= 1'b0;
                    div_clear <= 1'b0;
                end
            endcase
        end
    end

    // Qualify on the registered state so a tick on the leaving edge still counts.
    assign count_en_c  = tick && (state == RUN);
    assign clear_cnt_c = (state == CLEAR);

    stopwatch_digit #(.N(MSEC_MOD)) u_msec (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (count_en_c),
        .clr       (clear_cnt_c),
        .count     (msec),
        .carry_out (msec_carry)
    );

    stopwatch_digit #(.N(SEC_MOD)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (msec_carry),
        .clr       (clear_cnt_c),
        .count     (sec),
        .carry_out (sec_carry)
    );

    stopwatch_digit #(.N(MIN_MOD)) u_min (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (sec_carry),
        .clr       (clear_cnt_c),
        .count     (min),
        .carry_out (min_carry)
    );

    stopwatch_digit #(.N(HOUR_MOD)) u_hour (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (min_carry),
        .clr       (clear_cnt_c),
        .count     (hour),
        .carry_out (hour_carry_unused)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl using reduced minute/hour moduli so a
// full rollover fits in a short run.
module tb_stopwatch_ctrl;

    localparam int unsigned MS_M  = 10;
    localparam int unsigned SC_M  = 60;
    localparam int unsigned MN_M  = 6;
    localparam int unsigned HR_M  = 4;
    localparam int unsigned TOTAL = MS_M * SC_M * MN_M * HR_M;

    typedef struct packed {
        logic [1:0] hour;
        logic [2:0] min;
        logic [5:0] sec;
        logic [3:0] msec;
        logic       running;
        logic       div_en;
        logic       div_clear;
    } obs_t;

    typedef struct {
        logic  rs;
        logic  clr;
        logic  tk;
        int    reps;
        obs_t  exp;
        string tag;
    } step_t;

    logic       clk;
    logic       reset;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       tick;
    logic       div_en;
    logic       div_clear;
    logic [3:0] msec;
    logic [5:0] sec;
    logic [2:0] min;
    logic [1:0] hour;
    logic       running;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];
    string tag_q[$];

    stopwatch_ctrl #(
        .MSEC_MOD (MS_M),
        .SEC_MOD  (SC_M),
        .MIN_MOD  (MN_M),
        .HOUR_MOD (HR_M)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .tick         (tick),
        .div_en       (div_en),
        .div_clear    (div_clear),
        .msec         (msec),
        .sec          (sec),
        .min          (min),
        .hour         (hour),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t expv(input int h, input int m, input int s, input int ms,
                                  input bit run, input bit dclr);
        obs_t r;
        r.hour      = 2'(h);
        r.min       = 3'(m);
        r.sec       = 6'(s);
        r.msec      = 4'(ms);
        r.running   = run;
        r.div_en    = run;
        r.div_clear = dclr;
        return r;
    endfunction

    function automatic obs_t snap();
        obs_t r;
        r.hour      = hour;
        r.min       = min;
        r.sec       = sec;
        r.msec      = msec;
        r.running   = running;
        r.div_en    = div_en;
        r.div_clear = div_clear;
        return r;
    endfunction

    function automatic step_t mk(input logic rs, input logic clr, input logic tk,
                                 input int reps, input obs_t e, input string tag);
        step_t s;
        s.rs = rs; s.clr = clr; s.tk = tk; s.reps = reps; s.exp = e; s.tag = tag;
        return s;
    endfunction

    task automatic test_reset();
        obs_t o, e;
        string tg;
        reset = 1'b1; btn_run_stop = 1'b0; btn_clear = 1'b0; tick = 1'b0;
        #1 reset = 1'b0;
        exp_q.push_back(expv(0, 0, 0, 0, 0, 0)); tag_q.push_back("reset_state");
        #2;
        e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        @(posedge clk); #3 reset = 1'b1;
        exp_q.push_back(expv(0, 0, 0, 0, 0, 0)); tag_q.push_back("after_release");
        cyc(); cyc();
        e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
    endtask

    task automatic test_run_ticks();
        step_t st[$];
        obs_t o, e;
        string tg;
        st.push_back(mk(1, 0, 0, 1,  expv(0, 0, 0, 0, 1, 0), "rs_edge_run"));
        st.push_back(mk(1, 0, 1, 25, expv(0, 0, 2, 5, 1, 0), "ticks_25"));
        st.push_back(mk(0, 0, 0, 1,  expv(0, 0, 2, 5, 1, 0), "rs_release"));
        st.push_back(mk(1, 0, 1, 1,  expv(0, 0, 2, 6, 0, 0), "tick_on_stop_edge"));
        st.push_back(mk(0, 1, 0, 1,  expv(0, 0, 2, 6, 0, 1), "clear_enter"));
        st.push_back(mk(0, 1, 0, 1,  expv(0, 0, 0, 0, 0, 0), "clear_done"));
        st.push_back(mk(0, 0, 0, 1,  expv(0, 0, 0, 0, 0, 0), "idle"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
    endtask

    task automatic test_wrap();
        step_t st[$];
        obs_t o, e;
        string tg;
        st.push_back(mk(1, 0, 0, 1,         expv(0, 0, 0, 0, 1, 0),  "wrap_run"));
        st.push_back(mk(0, 0, 1, TOTAL - 1, expv(3, 5, 59, 9, 1, 0), "preload_max"));
        st.push_back(mk(0, 0, 1, 1,         expv(0, 0, 0, 0, 1, 0),  "wrap_to_zero"));
        st.push_back(mk(0, 0, 1, 3,         expv(0, 0, 0, 3, 1, 0),  "count_after_wrap"));
        st.push_back(mk(1, 0, 0, 1,         expv(0, 0, 0, 3, 0, 0),  "wrap_stop"));
        st.push_back(mk(0, 1, 0, 2,         expv(0, 0, 0, 0, 0, 0),  "wrap_clear"));
        st.push_back(mk(0, 0, 0, 1,         expv(0, 0, 0, 0, 0, 0),  "wrap_idle"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
    endtask

    task automatic test_clear_in_run();
        step_t st[$];
        obs_t o, e;
        string tg;
        st.push_back(mk(1, 0, 0, 1,  expv(0, 0, 0, 0, 1, 0), "cr_run"));
        st.push_back(mk(0, 0, 1, 34, expv(0, 0, 3, 4, 1, 0), "cr_ticks_34"));
        st.push_back(mk(0, 1, 0, 1,  expv(0, 0, 3, 4, 1, 0), "clear_ignored_in_run"));
        st.push_back(mk(0, 0, 0, 1,  expv(0, 0, 3, 4, 1, 0), "still_running"));
        st.push_back(mk(1, 0, 0, 1,  expv(0, 0, 3, 4, 0, 0), "cr_stop"));
        st.push_back(mk(0, 0, 1, 3,  expv(0, 0, 3, 4, 0, 0), "cr_stop_hold"));
        st.push_back(mk(0, 1, 0, 1,  expv(0, 0, 3, 4, 0, 1), "div_clear_high"));
        st.push_back(mk(0, 1, 0, 1,  expv(0, 0, 0, 0, 0, 0), "div_clear_one_cycle"));
        st.push_back(mk(0, 0, 0, 2,  expv(0, 0, 0, 0, 0, 0), "cr_after_clear"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
    endtask

    task automatic test_simultaneous();
        step_t st[$];
        obs_t o, e;
        string tg;
        st.push_back(mk(1, 0, 0, 1, expv(0, 0, 0, 0, 1, 0), "sim_run"));
        st.push_back(mk(0, 0, 1, 7, expv(0, 0, 0, 7, 1, 0), "sim_ticks_7"));
        st.push_back(mk(1, 0, 0, 1, expv(0, 0, 0, 7, 0, 0), "sim_stop"));
        st.push_back(mk(0, 0, 0, 1, expv(0, 0, 0, 7, 0, 0), "sim_idle"));
        st.push_back(mk(1, 1, 0, 1, expv(0, 0, 0, 7, 0, 1), "both_clear_wins"));
        st.push_back(mk(1, 1, 0, 1, expv(0, 0, 0, 0, 0, 0), "both_back_to_stop"));
        st.push_back(mk(0, 0, 0, 3, expv(0, 0, 0, 0, 0, 0), "both_never_run"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
    endtask

    task automatic test_hold_and_stop_ticks();
        step_t st[$];
        obs_t  o, e;
        string tg;
        int    changes = 0;
        logic  prev_run;
        prev_run = running;
        btn_run_stop = 1'b1; btn_clear = 1'b0; tick = 1'b1;
        exp_q.push_back(expv(0, 0, 1, 2, 1, 0)); tag_q.push_back("hold_100_cycles");
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (running !== prev_run) changes++;
            prev_run = running;
            if (i == 12) tick = 1'b0;
        end
        n_checks++;
        if (changes !== 1) begin
            n_fail++;
            $display("FAIL hold_single_transition observed=%0d expected=1", changes);
        end
        e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        st.push_back(mk(0, 0, 0, 1,  expv(0, 0, 1, 2, 1, 0), "hold_release"));
        st.push_back(mk(1, 0, 0, 1,  expv(0, 0, 1, 2, 0, 0), "hold_stop"));
        st.push_back(mk(0, 0, 1, 20, expv(0, 0, 1, 2, 0, 0), "ticks_in_stop"));
        st.push_back(mk(0, 0, 0, 1,  expv(0, 0, 1, 2, 0, 0), "stop_idle"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
    endtask

    task automatic test_reset_mid_run();
        step_t st[$];
        obs_t o, e;
        string tg;
        st.push_back(mk(0, 1, 0, 1,   expv(0, 0, 1, 2, 0, 1), "mr_clear"));
        st.push_back(mk(0, 0, 0, 1,   expv(0, 0, 0, 0, 0, 0), "mr_cleared"));
        st.push_back(mk(1, 0, 0, 1,   expv(0, 0, 0, 0, 1, 0), "mr_run"));
        st.push_back(mk(1, 0, 1, 623, expv(0, 1, 2, 3, 1, 0), "mr_at_0_1_2_3"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
        // Assert reset between edges; outputs must clear before the next clock.
        #2 reset = 1'b0;
        exp_q.push_back(expv(0, 0, 0, 0, 0, 0)); tag_q.push_back("async_reset_immediate");
        #1;
        e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        cyc(); cyc();
        @(posedge clk); #3 reset = 1'b1;
        exp_q.push_back(expv(0, 0, 0, 0, 0, 0)); tag_q.push_back("held_button_no_pulse");
        repeat (3) cyc();
        e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
        n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        st.delete();
        st.push_back(mk(0, 0, 0, 1, expv(0, 0, 0, 0, 0, 0), "post_reset_idle"));
        st.push_back(mk(1, 0, 0, 1, expv(0, 0, 0, 0, 1, 0), "post_reset_run"));
        st.push_back(mk(0, 0, 1, 4, expv(0, 0, 0, 4, 1, 0), "post_reset_ticks"));
        st.push_back(mk(1, 0, 0, 1, expv(0, 0, 0, 4, 0, 0), "post_reset_stop"));
        foreach (st[i]) begin
            btn_run_stop = st[i].rs; btn_clear = st[i].clr; tick = st[i].tk;
            exp_q.push_back(st[i].exp); tag_q.push_back(st[i].tag);
            repeat (st[i].reps) cyc();
            e = exp_q.pop_front(); tg = tag_q.pop_front(); o = snap();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL %s observed=%h expected=%h", tg, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_wrap();
        test_clear_in_run();
        test_simultaneous();
        test_hold_and_stop_ticks();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
